// File: rtl/hbmc_pkg.sv
// Shared definitions for the HyperBus controller read/write data paths.
package hbmc_pkg;

    // Packer / unpacker control states.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } hbmc_state_e;

    // Bits needed to hold values 0 .. value-1 (value >= 2 assumed).
    function automatic int clog2(input int value);
        int width_v;
        width_v = 32'sd0;
        while ((32'sd1 << width_v) < value) begin
            width_v = width_v + 32'sd1;
        end
        return width_v;
    endfunction

endpackage

// File: rtl/hbmc_rd_timeout.sv
// Loadable saturating down-counter. `clear` reloads the start value,
// `enable` counts down one step, and `expired` flags a count of zero.
// Shared by the read packer and the write path.
module hbmc_rd_timeout #(
    parameter int CNT_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [CNT_WIDTH-1:0] load_val,
    output logic                 expired
);

    logic [CNT_WIDTH-1:0] count_r;

    // Reload on reset or clear, otherwise count down and hold at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= load_val;
        end else if (clear) begin
            count_r <= load_val;
        end else if (enable && (count_r != {CNT_WIDTH{1'b0}})) begin
            count_r <= count_r - {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == {CNT_WIDTH{1'b0}});

endmodule

// File: rtl/hbmc_rd_packer.sv
// Read-data packer: assembles DDR beats leaving the elastic buffer into
// wide words for the read data FIFO, counting beats against the commanded
// burst length and aborting the burst if RWDS goes quiet for too long.
module hbmc_rd_packer
    import hbmc_pkg::*;
#(
    parameter int DIN_WIDTH      = 16,
    parameter int PACK_RATIO     = 2,
    parameter int LEN_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [LEN_WIDTH-1:0]            cmd_len,
    input  logic                            din_valid,
    input  logic [DIN_WIDTH-1:0]            din,
    output logic                            dout_valid,
    output logic [DIN_WIDTH*PACK_RATIO-1:0] dout_data,
    output logic [PACK_RATIO-1:0]           dout_strb,
    output logic                            dout_last,
    output logic                            done,
    output logic                            err_timeout
);

    localparam int WORD_W = DIN_WIDTH * PACK_RATIO;
    localparam int LANE_W = clog2(PACK_RATIO);
    localparam int TMO_W  = clog2(TIMEOUT_CYCLES);
    // Counter starts at TIMEOUT_CYCLES-1 so the abort lands TIMEOUT_CYCLES
    // cycles after the last beat (or after command acceptance).
    localparam logic [TMO_W-1:0]  TMO_LOAD  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(PACK_RATIO - 1);

    hbmc_state_e            state_r, state_nxt_s;
    logic [LEN_WIDTH-1:0]   len_r, len_nxt_s;
    logic [LEN_WIDTH-1:0]   beat_cnt_r, beat_nxt_s, beat_inc_s;
    logic [LANE_W-1:0]      lane_idx_r, lane_nxt_s;
    logic [WORD_W-1:0]      acc_r, acc_nxt_s, word_data_s;
    logic [PACK_RATIO-1:0]  strb_r, strb_nxt_s, word_strb_s;
    logic                   cmd_ready_r, cmd_ready_nxt_s;
    logic                   dout_valid_r, dout_valid_nxt_s;
    logic [WORD_W-1:0]      dout_data_r, dout_data_nxt_s;
    logic [PACK_RATIO-1:0]  dout_strb_r, dout_strb_nxt_s;
    logic                   dout_last_r, dout_last_nxt_s;
    logic                   done_r, done_nxt_s;
    logic                   err_r, err_nxt_s;
    logic                   tmo_clear_s, tmo_enable_s, tmo_expired_s;
    logic                   lane_full_s, last_beat_s;

    // Idle-cycle watchdog: held at its start value outside a burst and on
    // every beat, counts down on each empty cycle inside a burst.
    assign tmo_clear_s  = (state_r != ST_RUN) || din_valid;
    assign tmo_enable_s = (state_r == ST_RUN) && !din_valid;

    hbmc_rd_timeout #(
        .CNT_WIDTH (TMO_W)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear    (tmo_clear_s),
        .enable   (tmo_enable_s),
        .load_val (TMO_LOAD),
        .expired  (tmo_expired_s)
    );

    // Current beat merged into the accumulator, and the burst/lane end tests.
    always_comb begin
        word_data_s = acc_r;
        word_data_s[lane_idx_r*DIN_WIDTH +: DIN_WIDTH] = din;
        word_strb_s = strb_r | ({{(PACK_RATIO-1){1'b0}}, 1'b1} << lane_idx_r);
        beat_inc_s  = beat_cnt_r + {{(LEN_WIDTH-1){1'b0}}, 1'b1};
        lane_full_s = (lane_idx_r == LANE_LAST);
        last_beat_s = (beat_inc_s == len_r);
    end

    // Next-state and next-output logic of the IDLE/RUN controller.
    always_comb begin
        state_nxt_s      = state_r;
        len_nxt_s        = len_r;
        beat_nxt_s       = beat_cnt_r;
        lane_nxt_s       = lane_idx_r;
        acc_nxt_s        = acc_r;
        strb_nxt_s       = strb_r;
        dout_valid_nxt_s = 1'b0;
        dout_data_nxt_s  = {WORD_W{1'b0}};
        dout_strb_nxt_s  = {PACK_RATIO{1'b0}};
        dout_last_nxt_s  = 1'b0;
        done_nxt_s       = 1'b0;
        err_nxt_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_ready_r && cmd_valid) begin
                    len_nxt_s  = cmd_len;
                    beat_nxt_s = {LEN_WIDTH{1'b0}};
                    lane_nxt_s = {LANE_W{1'b0}};
                    acc_nxt_s  = {WORD_W{1'b0}};
                    strb_nxt_s = {PACK_RATIO{1'b0}};
                    if (cmd_len == {LEN_WIDTH{1'b0}}) begin
                        // Empty burst: acknowledge without moving data.
                        done_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (din_valid) begin
                    beat_nxt_s = beat_inc_s;
                    if (lane_full_s || last_beat_s) begin
                        dout_valid_nxt_s = 1'b1;
                        dout_data_nxt_s  = word_data_s;
                        dout_strb_nxt_s  = word_strb_s;
                        dout_last_nxt_s  = last_beat_s;
                        done_nxt_s       = last_beat_s;
                        acc_nxt_s        = {WORD_W{1'b0}};
                        strb_nxt_s       = {PACK_RATIO{1'b0}};
                        lane_nxt_s       = {LANE_W{1'b0}};
                        if (last_beat_s) begin
                            state_nxt_s = ST_IDLE;
                        end else begin
                            state_nxt_s = ST_RUN;
                        end
                    end else begin
                        acc_nxt_s  = word_data_s;
                        strb_nxt_s = word_strb_s;
                        lane_nxt_s = lane_idx_r + {{(LANE_W-1){1'b0}}, 1'b1};
                    end
                end else if (tmo_expired_s) begin
                    // Abort: flush whatever lanes are filled as the last word.
                    dout_valid_nxt_s = 1'b1;
                    dout_data_nxt_s  = acc_r;
                    dout_strb_nxt_s  = strb_r;
                    dout_last_nxt_s  = 1'b1;
                    done_nxt_s       = 1'b1;
                    err_nxt_s        = 1'b1;
                    acc_nxt_s        = {WORD_W{1'b0}};
                    strb_nxt_s       = {PACK_RATIO{1'b0}};
                    lane_nxt_s       = {LANE_W{1'b0}};
                    state_nxt_s      = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        cmd_ready_nxt_s = (state_nxt_s == ST_IDLE);
    end

    // State, datapath and output registers; reset discards any burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            len_r        <= {LEN_WIDTH{1'b0}};
            beat_cnt_r   <= {LEN_WIDTH{1'b0}};
            lane_idx_r   <= {LANE_W{1'b0}};
            acc_r        <= {WORD_W{1'b0}};
            strb_r       <= {PACK_RATIO{1'b0}};
            cmd_ready_r  <= 1'b0;
            dout_valid_r <= 1'b0;
            dout_data_r  <= {WORD_W{1'b0}};
            dout_strb_r  <= {PACK_RATIO{1'b0}};
            dout_last_r  <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            len_r        <= len_nxt_s;
            beat_cnt_r   <= beat_nxt_s;
            lane_idx_r   <= lane_nxt_s;
            acc_r        <= acc_nxt_s;
            strb_r       <= strb_nxt_s;
            cmd_ready_r  <= cmd_ready_nxt_s;
            dout_valid_r <= dout_valid_nxt_s;
            dout_data_r  <= dout_data_nxt_s;
            dout_strb_r  <= dout_strb_nxt_s;
            dout_last_r  <= dout_last_nxt_s;
            done_r       <= done_nxt_s;
            err_r        <= err_nxt_s;
        end
    end

    assign cmd_ready   = cmd_ready_r;
    assign dout_valid  = dout_valid_r;
    assign dout_data   = dout_data_r;
    assign dout_strb   = dout_strb_r;
    assign dout_last   = dout_last_r;
    assign done        = done_r;
    assign err_timeout = err_r;

endmodule

// File: tb/tb_hbmc_rd_packer.sv
// Directed bench for hbmc_rd_packer with default parameters
// (16-bit beats, 2 beats per word, 64-cycle timeout).
module tb_hbmc_rd_packer;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_len;
    logic        din_valid;
    logic [15:0] din;
    logic        dout_valid;
    logic [31:0] dout_data;
    logic [1:0]  dout_strb;
    logic        dout_last;
    logic        done;
    logic        err_timeout;

    int vectors;
    int miscompares;
    int stray_dv;
    int stray_err;

    hbmc_rd_packer #(
        .DIN_WIDTH      (16),
        .PACK_RATIO     (2),
        .LEN_WIDTH      (16),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_len     (cmd_len),
        .din_valid   (din_valid),
        .din         (din),
        .dout_valid  (dout_valid),
        .dout_data   (dout_data),
        .dout_strb   (dout_strb),
        .dout_last   (dout_last),
        .done        (done),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check a complete output word plus its side-band flags.
    task automatic check_word(input string tag, input logic [31:0] data, input logic [1:0] strb,
                              input logic last, input logic dn, input logic err);
        check({tag, ".valid"}, {63'd0, dout_valid}, 64'd1);
        check({tag, ".data"},  {32'd0, dout_data},  {32'd0, data});
        check({tag, ".strb"},  {62'd0, dout_strb},  {62'd0, strb});
        check({tag, ".last"},  {63'd0, dout_last},  {63'd0, last});
        check({tag, ".done"},  {63'd0, done},       {63'd0, dn});
        check({tag, ".err"},   {63'd0, err_timeout}, {63'd0, err});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_len     = 16'd0;
        din_valid   = 1'b0;
        din         = 16'd0;

        // ---------------- reset state
        step(); step(); step();
        check("rst.cmd_ready", {63'd0, cmd_ready}, 64'd0);
        check("rst.dout_valid", {63'd0, dout_valid}, 64'd0);
        check("rst.dout_data", {32'd0, dout_data}, 64'd0);
        check("rst.dout_strb", {62'd0, dout_strb}, 64'd0);
        check("rst.dout_last", {63'd0, dout_last}, 64'd0);
        check("rst.done", {63'd0, done}, 64'd0);
        check("rst.err", {63'd0, err_timeout}, 64'd0);
        rst = 1'b0;
        step();
        check("rst.ready_rise", {63'd0, cmd_ready}, 64'd1);

        // ---------------- aligned burst, length 4
        cmd_valid = 1'b1; cmd_len = 16'd4;
        step();
        check("al.ready_low", {63'd0, cmd_ready}, 64'd0);
        cmd_valid = 1'b0;
        din_valid = 1'b1; din = 16'h1111;
        step();
        check("al.no_word1", {63'd0, dout_valid}, 64'd0);
        din = 16'h2222;
        step();
        check_word("al.w0", 32'h2222_1111, 2'b11, 1'b0, 1'b0, 1'b0);
        din = 16'h3333;
        step();
        check("al.no_word3", {63'd0, dout_valid}, 64'd0);
        din = 16'h4444;
        step();
        check_word("al.w1", 32'h4444_3333, 2'b11, 1'b1, 1'b1, 1'b0);
        check("al.ready_back", {63'd0, cmd_ready}, 64'd1);
        din_valid = 1'b0;
        step();
        check("al.done_pulse", {63'd0, done}, 64'd0);
        check("al.valid_pulse", {63'd0, dout_valid}, 64'd0);

        // ---------------- odd length, 3 beats
        cmd_valid = 1'b1; cmd_len = 16'd3;
        step();
        cmd_valid = 1'b0;
        din_valid = 1'b1; din = 16'hAAAA;
        step();
        din = 16'hBBBB;
        step();
        check_word("odd.w0", 32'hBBBB_AAAA, 2'b11, 1'b0, 1'b0, 1'b0);
        din = 16'hCCCC;
        step();
        check_word("odd.w1", 32'h0000_CCCC, 2'b01, 1'b1, 1'b1, 1'b0);
        din_valid = 1'b0;
        step();

        // ---------------- gapped input, 5 idle cycles between beats
        cmd_valid = 1'b1; cmd_len = 16'd4;
        step();
        cmd_valid = 1'b0;
        stray_dv  = 0;
        stray_err = 0;
        for (int b = 0; b < 4; b++) begin
            din_valid = 1'b1;
            din = (b == 0) ? 16'h1111 : (b == 1) ? 16'h2222 : (b == 2) ? 16'h3333 : 16'h4444;
            step();
            if (b == 1) begin
                check_word("gap.w0", 32'h2222_1111, 2'b11, 1'b0, 1'b0, 1'b0);
            end else if (b == 3) begin
                check_word("gap.w1", 32'h4444_3333, 2'b11, 1'b1, 1'b1, 1'b0);
            end else begin
                check("gap.no_word", {63'd0, dout_valid}, 64'd0);
            end
            din_valid = 1'b0;
            if (b < 3) begin
                for (int g = 0; g < 5; g++) begin
                    step();
                    stray_dv  = stray_dv + int'(dout_valid);
                    stray_err = stray_err + int'(err_timeout);
                end
            end
        end
        check("gap.idle_valid", stray_dv, 64'd0);
        check("gap.idle_err", stray_err, 64'd0);
        step();

        // ---------------- timeout, one beat then silence
        cmd_valid = 1'b1; cmd_len = 16'd4;
        step();
        cmd_valid = 1'b0;
        din_valid = 1'b1; din = 16'hABCD;
        step();
        din_valid = 1'b0;
        stray_dv  = 0;
        stray_err = 0;
        for (int c = 0; c < 63; c++) begin
            step();
            stray_dv  = stray_dv + int'(dout_valid);
            stray_err = stray_err + int'(err_timeout);
        end
        check("tmo.early_valid", stray_dv, 64'd0);
        check("tmo.early_err", stray_err, 64'd0);
        check("tmo.ready_low", {63'd0, cmd_ready}, 64'd0);
        step();
        check_word("tmo.word", 32'h0000_ABCD, 2'b01, 1'b1, 1'b1, 1'b1);
        check("tmo.ready_back", {63'd0, cmd_ready}, 64'd1);

        // ---------------- back-to-back: command in the done cycle, 2 beats
        cmd_valid = 1'b1; cmd_len = 16'd2;
        step();
        check("b2b.accepted", {63'd0, cmd_ready}, 64'd0);
        check("b2b.err_pulse", {63'd0, err_timeout}, 64'd0);
        cmd_valid = 1'b0;
        din_valid = 1'b1; din = 16'h5555;
        step();
        check("b2b.no_word", {63'd0, dout_valid}, 64'd0);
        din = 16'h6666;
        step();
        check_word("b2b.w0", 32'h6666_5555, 2'b11, 1'b1, 1'b1, 1'b0);
        din_valid = 1'b0;

        // ---------------- zero-length command right after done
        cmd_valid = 1'b1; cmd_len = 16'd0;
        step();
        check("len0.done", {63'd0, done}, 64'd1);
        check("len0.no_valid", {63'd0, dout_valid}, 64'd0);
        check("len0.ready", {63'd0, cmd_ready}, 64'd1);
        cmd_valid = 1'b0;
        step();
        check("len0.done_pulse", {63'd0, done}, 64'd0);

        // ---------------- stray beats in IDLE
        stray_dv = 0;
        din_valid = 1'b1;
        for (int s = 0; s < 3; s++) begin
            din = 16'h7770 + 16'(s);
            step();
            stray_dv = stray_dv + int'(dout_valid) + int'(done);
        end
        din_valid = 1'b0;
        step();
        stray_dv = stray_dv + int'(dout_valid) + int'(done);
        check("idle.stray", stray_dv, 64'd0);
        check("idle.ready", {63'd0, cmd_ready}, 64'd1);

        // ---------------- reset in the middle of a burst
        cmd_valid = 1'b1; cmd_len = 16'd4;
        step();
        cmd_valid = 1'b0;
        din_valid = 1'b1; din = 16'h9999;
        step();
        din_valid = 1'b0;
        rst = 1'b1;
        step();
        check("mrst.ready", {63'd0, cmd_ready}, 64'd0);
        check("mrst.valid", {63'd0, dout_valid}, 64'd0);
        check("mrst.done", {63'd0, done}, 64'd0);
        rst = 1'b0;
        step();
        check("mrst.ready_rise", {63'd0, cmd_ready}, 64'd1);
        stray_dv = 0;
        for (int s = 0; s < 80; s++) begin
            step();
            stray_dv = stray_dv + int'(dout_valid) + int'(done) + int'(err_timeout);
        end
        check("mrst.quiet", stray_dv, 64'd0);

        // After the reset the packer must still work: a 2-beat burst.
        cmd_valid = 1'b1; cmd_len = 16'd2;
        step();
        cmd_valid = 1'b0;
        din_valid = 1'b1; din = 16'h0F0F;
        step();
        din = 16'hF0F0;
        step();
        check_word("mrst.after", 32'hF0F0_0F0F, 2'b11, 1'b1, 1'b1, 1'b0);
        din_valid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
